// File: rtl/reg_fork_two_rd.sv
// reg_fork_two_rd
//   One-writer, two-reader fork buffer. Every word written is delivered to
//   reader A and to reader B independently. A slot is only reused once both
//   readers have consumed it, so a slow reader is never overwritten.
//
// Ports
//   CLK              clock, all state changes on posedge
//   RST              asynchronous active-high reset
//   ENQ, D_IN        write strobe and data; accepted only while FULL_N=1
//   FULL_N           1 = at least one slot is free
//   DEQA / DEQB      per-reader dequeue strobes; accepted only while EMPTY*_N=1
//   EMPTYA_N/EMPTYB_N 1 = that reader has unread data
//   D_OUTA / D_OUTB  head entry for each reader
//   ERR              sticky flag: a strobe arrived while its status forbade it
//
// All status outputs depend on registered state only; there is no
// combinational path from the strobes to FULL_N/EMPTY*_N/D_OUT*.

module reg_fork_two_rd #(
  parameter int width = 1,
  parameter int depth = 2,
  parameter int ptr_w = $clog2(depth) + 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ENQ,
  input  logic [width-1:0] D_IN,
  output logic             FULL_N,
  input  logic             DEQA,
  output logic             EMPTYA_N,
  output logic [width-1:0] D_OUTA,
  input  logic             DEQB,
  output logic             EMPTYB_N,
  output logic [width-1:0] D_OUTB,
  output logic             ERR
);

  localparam int              ADDR_W  = ptr_w - 1;
  localparam logic [ptr_w-1:0] DEPTH_P = ptr_w'(depth);

  logic [ptr_w-1:0] wr_q,  wr_d;
  logic [ptr_w-1:0] rda_q, rda_d;
  logic [ptr_w-1:0] rdb_q, rdb_d;
  logic             err_q, err_d;
  logic [width-1:0] mem_q [depth];

  logic [ptr_w-1:0] cnt_a, cnt_b, occ;
  logic             enq_ok, deqa_ok, deqb_ok;

  // Pointer differences wrap modulo 2*depth thanks to the extra MSB, so a
  // plain subtraction gives the per-reader fill level.
  assign cnt_a = wr_q - rda_q;
  assign cnt_b = wr_q - rdb_q;
  // The lagging reader determines how many slots are still held.
  assign occ   = (cnt_a > cnt_b) ? cnt_a : cnt_b;

  assign FULL_N   = (occ < DEPTH_P);
  assign EMPTYA_N = (cnt_a != '0);
  assign EMPTYB_N = (cnt_b != '0);
  assign D_OUTA   = mem_q[rda_q[ADDR_W-1:0]];
  assign D_OUTB   = mem_q[rdb_q[ADDR_W-1:0]];
  assign ERR      = err_q;

  // Gating uses pre-edge status, so an ENQ while full is rejected even if a
  // same-cycle DEQ frees a slot.
  assign enq_ok  = ENQ  & FULL_N;
  assign deqa_ok = DEQA & EMPTYA_N;
  assign deqb_ok = DEQB & EMPTYB_N;

  always_comb begin
    wr_d  = wr_q;
    rda_d = rda_q;
    rdb_d = rdb_q;
    err_d = err_q;
    if (enq_ok)  wr_d  = wr_q  + 1'b1;
    if (deqa_ok) rda_d = rda_q + 1'b1;
    if (deqb_ok) rdb_d = rdb_q + 1'b1;
    if ((ENQ & ~FULL_N) | (DEQA & ~EMPTYA_N) | (DEQB & ~EMPTYB_N)) err_d = 1'b1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_q  <= '0;
      rda_q <= '0;
      rdb_q <= '0;
      err_q <= 1'b0;
    end else begin
      wr_q  <= wr_d;
      rda_q <= rda_d;
      rdb_q <= rdb_d;
      err_q <= err_d;
    end
  end

  // Storage is deliberately not reset; outputs are don't-care while empty.
  always_ff @(posedge CLK) begin
    if (enq_ok) mem_q[wr_q[ADDR_W-1:0]] <= D_IN;
  end

endmodule

// File: tb/tb_reg_fork_two_rd.sv
module tb_reg_fork_two_rd;

  localparam int W = 8;
  localparam int D = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         enq, deqa, deqb;
  logic [W-1:0] d_in;
  logic         full_n, emptya_n, emptyb_n, err;
  logic [W-1:0] d_outa, d_outb;

  int errors = 0;
  int checks = 0;

  reg_fork_two_rd #(.width(W), .depth(D)) dut (
    .CLK(clk), .RST(rst),
    .ENQ(enq), .D_IN(d_in), .FULL_N(full_n),
    .DEQA(deqa), .EMPTYA_N(emptya_n), .D_OUTA(d_outa),
    .DEQB(deqb), .EMPTYB_N(emptyb_n), .D_OUTB(d_outb),
    .ERR(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         enq;
    logic [W-1:0] din;
    logic         deqa;
    logic         deqb;
    logic         full_n;
    logic         ea;
    logic         eb;
    logic [W-1:0] oa;
    logic [W-1:0] ob;
    logic         err;
  } vec_t;

  vec_t vt [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in;
    enq = 1'b0; deqa = 1'b0; deqb = 1'b0; d_in = '0;
  endtask

  task automatic do_reset;
    idle_in();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_full_n"},   full_n,   1'b1);
    chk({tag, "_emptya_n"}, emptya_n, 1'b0);
    chk({tag, "_emptyb_n"}, emptyb_n, 1'b0);
    chk({tag, "_err"},      err,      1'b0);
  endtask

  byte unsigned qa[$];
  byte unsigned qb[$];

  initial begin
    // enq din  deqa deqb | full ea eb oa ob err
    // basic broadcast
    vt[0]  = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h11, 8'h11, 1'b0};
    vt[1]  = '{1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 8'h11, 1'b0};
    vt[2]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h22, 8'h11, 1'b0};
    vt[3]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h22, 8'h22, 1'b0};
    vt[4]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0};
    // skewed readers
    vt[5]  = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h11, 8'h11, 1'b0};
    vt[6]  = '{1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 8'h11, 1'b0};
    vt[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h22, 8'h11, 1'b0};
    vt[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h11, 1'b0};
    vt[9]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 8'h22, 1'b0};
    vt[10] = '{1'b1, 8'h33, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h33, 8'h22, 1'b0};
    // full with same-cycle ENQ + both DEQs: 0x44 rejected, both advance
    vt[11] = '{1'b1, 8'h44, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 8'h33, 1'b1};
    // next write must land where 0x44 would have gone
    vt[12] = '{1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h55, 8'h33, 1'b1};
    vt[13] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h55, 8'h55, 1'b1};
    vt[14] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1};

    idle_in();
    rst = 1'b1;
    step();
    chk_reset_state("reset");
    step();
    rst = 1'b0;
    step();
    chk_reset_state("post_reset_idle");

    for (int i = 0; i < 15; i++) begin
      enq = vt[i].enq; d_in = vt[i].din; deqa = vt[i].deqa; deqb = vt[i].deqb;
      step();
      idle_in();
      chk($sformatf("v%0d_full_n", i),   full_n,   vt[i].full_n);
      chk($sformatf("v%0d_emptya_n", i), emptya_n, vt[i].ea);
      chk($sformatf("v%0d_emptyb_n", i), emptyb_n, vt[i].eb);
      chk($sformatf("v%0d_err", i),      err,      vt[i].err);
      if (vt[i].ea) chk($sformatf("v%0d_d_outa", i), d_outa, vt[i].oa);
      if (vt[i].eb) chk($sformatf("v%0d_d_outb", i), d_outb, vt[i].ob);
    end

    // Underflow on reader B: rdb must not move, ERR sticks
    do_reset();
    deqb = 1'b1;
    step();
    idle_in();
    chk("underflow_err", err, 1'b1);
    chk("underflow_emptyb_n", emptyb_n, 1'b0);
    enq = 1'b1; d_in = 8'h5A;
    step();
    idle_in();
    chk("underflow_rdb_held_emptyb_n", emptyb_n, 1'b1);
    chk("underflow_rdb_held_d_outb", d_outb, 8'h5A);
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("underflow_err_sticky%0d", i), err, 1'b1);
    end

    // Random wrap stress against a queue model
    do_reset();
    for (int cyc = 0; cyc < 1000; cyc++) begin
      logic e, a, b;
      int   occ;
      occ = (qa.size() > qb.size()) ? qa.size() : qb.size();
      chk("stress_full_n", full_n, (occ < D));
      chk("stress_emptya_n", emptya_n, (qa.size() != 0));
      chk("stress_emptyb_n", emptyb_n, (qb.size() != 0));
      e = ($urandom_range(0, 1) == 1) && full_n;
      a = ($urandom_range(0, 2) != 0) && emptya_n;
      b = ($urandom_range(0, 3) == 0) && emptyb_n;
      if (a && qa.size() != 0) begin
        chk("stress_d_outa", d_outa, qa[0]);
        void'(qa.pop_front());
      end
      if (b && qb.size() != 0) begin
        chk("stress_d_outb", d_outb, qb[0]);
        void'(qb.pop_front());
      end
      enq = e; deqa = a; deqb = b; d_in = W'($urandom);
      if (e) begin
        qa.push_back(d_in);
        qb.push_back(d_in);
      end
      step();
      idle_in();
      chk("stress_err", err, 1'b0);
    end

    // Async reset between clock edges with one entry pending
    do_reset();
    enq = 1'b1; d_in = 8'h77;
    step();
    idle_in();
    chk("async_pre_emptya_n", emptya_n, 1'b1);
    deqb = 1'b1; deqa = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    chk_reset_state("async_rst");
    step();
    rst = 1'b0;
    idle_in();
    step();
    chk_reset_state("async_after");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
